// File: rtl/sreg_load_ctrl.sv
// Serial config-chain loader: takes NUM_WORDS host words, shifts each MSB-first onto sout, then pulses update/done.
// Latency: word accepted at edge t -> shift_en in cycles t+1..t+WORD_W (SHIFT_DIV=1); update one cycle after the last shift.
// Backpressure: wr_ready only high while waiting for a word; host may stall indefinitely. Optional SREG_READBACK_EN adds sin capture.
module sreg_load_ctrl #(
    parameter int WORD_W    = 8,
    parameter int NUM_WORDS = 4,
    parameter int SHIFT_DIV = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              wr_valid,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              busy,
    output logic              sout,
    output logic              shift_en,
    output logic              update,
    output logic              done
`ifdef SREG_READBACK_EN
    ,
    input  logic              sin,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid
`endif
);

    localparam int BIT_W  = $clog2(WORD_W + 1);
    localparam int WCNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int DIV_W  = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
    localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(NUM_WORDS - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SHIFT_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_WORD = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_UPDATE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                wr_ready_q, wr_ready_d;
    logic                busy_q, busy_d;
    logic                sout_q, sout_d;
    logic                shift_en_q, shift_en_d;
    logic                update_q, update_d;
    logic                tick;

    // The chain shifts on the edge that ends a tick cycle.
    assign tick = (state_q == ST_SHIFT) && (div_cnt_q == DIV_LAST);

    // Next-state logic; outputs are computed from the next state so they are registered yet cycle-accurate.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        div_cnt_d  = div_cnt_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d    = ST_WAIT_WORD;
                        word_cnt_d = '0;
                    end
                end
                ST_WAIT_WORD: begin
                    if (wr_valid && wr_ready_q) begin
                        shreg_d   = wr_data;
                        bit_cnt_d = '0;
                        div_cnt_d = '0;
                        state_d   = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        div_cnt_d = '0;
                        shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            if (word_cnt_q == WORD_LAST) begin
                                state_d = ST_UPDATE;
                            end else begin
                                word_cnt_d = word_cnt_q + WCNT_W'(1);
                                state_d    = ST_WAIT_WORD;
                            end
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        wr_ready_d = (state_d == ST_WAIT_WORD);
        busy_d     = (state_d != ST_IDLE);
        shift_en_d = (state_d == ST_SHIFT) && (div_cnt_d == DIV_LAST);
        sout_d     = shift_en_d && shreg_d[WORD_W-1];
        update_d   = (state_d == ST_UPDATE);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            div_cnt_q  <= '0;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            sout_q     <= 1'b0;
            shift_en_q <= 1'b0;
            update_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            div_cnt_q  <= div_cnt_d;
            wr_ready_q <= wr_ready_d;
            busy_q     <= busy_d;
            sout_q     <= sout_d;
            shift_en_q <= shift_en_d;
            update_q   <= update_d;
        end
    end

    assign wr_ready = wr_ready_q;
    assign busy     = busy_q;
    assign sout     = sout_q;
    assign shift_en = shift_en_q;
    assign update   = update_q;
    assign done     = update_q;

`ifdef SREG_READBACK_EN
    logic [WORD_W-1:0] rd_sh_q, rd_sh_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    // Capture the chain's outgoing bit on every shift; publish a word after its last shift unless aborted.
    always_comb begin
        rd_sh_d    = rd_sh_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (tick) begin
            rd_sh_d = {rd_sh_q[WORD_W-2:0], sin};
            if ((bit_cnt_q == BIT_LAST) && !abort) begin
                rd_data_d  = rd_sh_d;
                rd_valid_d = 1'b1;
            end
        end
    end

    // Readback capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_sh_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_sh_q    <= rd_sh_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule
